// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared PPU constants, the VSQ reader FSM state type and small helpers.
// Imported by vsq_recip_div and vsq_quant_reader.
// ---------------------------------------------------------------------------
package ppu_pkg;

  localparam int LANES      = 16;
  localparam int IN_W       = 18;
  localparam int OUT_W      = 8;
  localparam int RECIP_FRAC = 16;
  localparam int QMAX       = 255;
  localparam int BUF_W      = LANES * IN_W + 8;   // 296, top byte is padding
  localparam int DIV_W      = 24;
  localparam int OUT_WORD_W = LANES * OUT_W + 8;  // 136, scale byte on top

  // Dividend of the reciprocal: 255 in fixed point with RECIP_FRAC fraction bits
  localparam logic [DIV_W-1:0] RECIP_DIVIDEND = DIV_W'(QMAX) << RECIP_FRAC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_RD,
    ST_LAT,
    ST_QNT,
    ST_OUT,
    ST_FIN
  } vsq_state_e;

  // Extract lane idx from a packed vector of 18-bit lanes (lane 0 at the LSBs)
  function automatic logic [IN_W-1:0] lane_slice(input logic [LANES*IN_W-1:0] vec,
                                                 input int idx);
    return vec[idx*IN_W +: IN_W];
  endfunction

  // Bit length of v: index of the highest set bit plus one, 0 for v == 0
  function automatic logic [7:0] msb_pos_plus1(input logic [IN_W-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) r = 8'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/vsq_recip_div.sv
// ---------------------------------------------------------------------------
// vsq_recip_div
// Sequential restoring divider, one quotient bit per cycle MSB first, fixed
// DIV_W (24) iterations. A zero divisor yields a zero quotient.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and begin (ignored while busy)
//   dividend    DIV_W-bit dividend
//   divisor     IN_W-bit divisor
//   busy        iteration in progress
//   done        high during the final iteration cycle
//   quotient    result, cleared on start, valid after the final iteration
// ---------------------------------------------------------------------------
module vsq_recip_div
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [IN_W-1:0]  divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic [DIV_W-1:0] quo_q;
  logic [IN_W:0]    rem_q;
  logic [IN_W-1:0]  dvs_q;
  logic [4:0]       step_q;

  logic [IN_W:0]    rem_shift;
  logic [IN_W:0]    rem_sub;
  logic             fits;

  // The remainder is always below the divisor, so one spare bit is enough
  // to hold it after shifting in the next dividend bit.
  always_comb begin
    rem_shift = {rem_q[IN_W-1:0], quo_q[DIV_W-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    fits      = (rem_shift >= {1'b0, dvs_q});
  end

  assign done = busy && (step_q == 5'(DIV_W - 1));

  // quo_q shifts dividend bits out at the top while quotient bits enter at
  // the bottom; after DIV_W steps it holds the full quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      step_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      quotient <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      step_q   <= '0;
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
      quotient <= '0;
    end else if (busy) begin
      rem_q  <= fits ? rem_sub : rem_shift;
      quo_q  <= {quo_q[DIV_W-2:0], fits};
      step_q <= step_q + 5'd1;
      if (done) begin
        busy     <= 1'b0;
        quotient <= (dvs_q == '0) ? '0 : {quo_q[DIV_W-2:0], fits};
      end
    end
  end

endmodule

// File: rtl/vsq_quant_reader.sv
// ---------------------------------------------------------------------------
// vsq_quant_reader
// Reads NUM_VEC post-ReLU vectors (16 lanes x 18 bits) from the PPU VSQ
// buffer and quantizes each lane to uint8 against the batch max, using a
// reciprocal 255/vec_max computed by a sequential divider.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       batch start pulse (PPU latch_done), ignored while busy
//   vec_max     batch max, sampled with start
//   rd_en       VSQ buffer read enable
//   rd_addr     VSQ buffer read address (vector counter)
//   rd_data     buffer data, one cycle after rd_en; top 8 bits unused
//   out_data    {scale_byte, lane15..lane0} quantized word
//   out_valid   out_data valid, held until out_ready
//   out_ready   downstream accept
//   busy        batch in progress, through the done cycle
//   done        one-cycle pulse after the last handshake
// Build option: PPU_QUANT_RNE_EN selects round-half-to-even instead of
// round-half-up.
// ---------------------------------------------------------------------------
module vsq_quant_reader
  import ppu_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int ADDR_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       vec_max,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [BUF_W-1:0]      rd_data,
  output logic [OUT_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int P_W = IN_W + DIV_W;
  localparam int Q_W = P_W - RECIP_FRAC + 1;

  vsq_state_e               state_q, state_d;
  logic [IN_W-1:0]          mreg_q;
  logic [ADDR_W-1:0]        vec_cnt_q;
  logic [LANES*IN_W-1:0]    lane_q;
  logic [LANES*OUT_W-1:0]   q_lanes;
  logic [DIV_W-1:0]         recip;
  logic                     accept;
  logic                     last_vec;
  logic                     div_start;
  logic                     div_busy;
  logic                     div_done;
  logic                     unused_pad_bits;

  assign unused_pad_bits = ^rd_data[BUF_W-1:LANES*IN_W];

  assign accept   = (state_q == ST_IDLE) && start;
  assign last_vec = (vec_cnt_q == ADDR_W'(NUM_VEC - 1));
  assign rd_addr  = vec_cnt_q;

  // The divider is launched for every batch, including vec_max == 0: it
  // clears its quotient on start and returns 0 for a zero divisor, so the
  // skipped-division path still sees recip == 0.
  assign div_start = accept && !div_busy;

  vsq_recip_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (RECIP_DIVIDEND),
    .divisor  (vec_max),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (recip)
  );

  // p = x * recip is 255*x/vec_max with RECIP_FRAC fraction bits; the
  // fraction is rounded away and the result clamped to QMAX.
  function automatic logic [OUT_W-1:0] quantize_lane(input logic [IN_W-1:0]  x,
                                                     input logic [DIV_W-1:0] r);
    logic [P_W-1:0] p;
    logic [Q_W-1:0] q;
    logic           round_up;
    p = P_W'(x) * P_W'(r);
`ifdef PPU_QUANT_RNE_EN
    // An exact half only rounds up when that lands on an even integer
    round_up = p[RECIP_FRAC-1] && ((|p[RECIP_FRAC-2:0]) || p[RECIP_FRAC]);
`else
    round_up = p[RECIP_FRAC-1];
`endif
    q = {1'b0, p[P_W-1:RECIP_FRAC]} + Q_W'(round_up);
    return (q > Q_W'(QMAX)) ? OUT_W'(QMAX) : q[OUT_W-1:0];
  endfunction

  always_comb begin
    q_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      q_lanes[i*OUT_W +: OUT_W] = quantize_lane(lane_slice(lane_q, i), recip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the control outputs, which are pure decodes of state
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (start) state_d = (vec_max == '0) ? ST_RD : ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_RD;
      ST_RD: begin
        rd_en   = 1'b1;
        state_d = ST_LAT;
      end
      ST_LAT:  state_d = ST_QNT;
      ST_QNT:  state_d = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_vec ? ST_FIN : ST_RD;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: batch max, vector counter (also the read address,
  // so it holds after the last read), lane capture and the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreg_q    <= '0;
      vec_cnt_q <= '0;
      lane_q    <= '0;
      out_data  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          mreg_q    <= vec_max;
          vec_cnt_q <= '0;
        end
        ST_LAT: lane_q <= rd_data[LANES*IN_W-1:0];
        ST_QNT: out_data <= {msb_pos_plus1(mreg_q), q_lanes};
        ST_OUT: if (out_ready && !last_vec) vec_cnt_q <= vec_cnt_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vsq_quant_reader.sv
// ---------------------------------------------------------------------------
// tb_vsq_quant_reader
// Directed and randomized batches against an arithmetic reference model of
// the quantizer (255*x/vec_max with the selected rounding, clamped to 255).
// ---------------------------------------------------------------------------
module tb_vsq_quant_reader;

  localparam int NUM_VEC = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [17:0]  vec_max;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [295:0] rd_data;
  logic [135:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [295:0] mem [0:NUM_VEC-1];
  logic [135:0] got_q[$];
  int           addr_q[$];
  int           done_total = 0;

  always #5 clk = ~clk;

  vsq_quant_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_max   (vec_max),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // VSQ buffer model with one cycle read latency, plus handshake/done monitors
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr[3:0]];
      addr_q.push_back(int'(rd_addr));
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (done) done_total <= done_total + 1;
  end

  function automatic logic [135:0] model_word(input int unsigned m, input logic [295:0] row);
    longint unsigned recip, p, whole, frac, q;
    logic [135:0]    w;
    int unsigned     v;
    int              scale;
    recip = (m == 0) ? 64'd0 : (64'd255 * 64'd65536) / 64'(m);
    scale = 0;
    v = m;
    while (v != 0) begin
      scale++;
      v = v >> 1;
    end
    w = '0;
    w[135:128] = 8'(scale);
    for (int i = 0; i < 16; i++) begin
      p = 64'(row[i*18 +: 18]) * recip;
      whole = p / 64'd65536;
      frac  = p % 64'd65536;
      if (frac > 64'd32768) q = whole + 1;
      else if (frac == 64'd32768) begin
`ifdef PPU_QUANT_RNE_EN
        q = (whole % 2 == 0) ? whole : whole + 1;
`else
        q = whole + 1;
`endif
      end else q = whole;
      if (q > 64'd255) q = 64'd255;
      w[i*8 +: 8] = 8'(q);
    end
    return w;
  endfunction

  task automatic check_output(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string ctx);
    check_output({ctx, "_rd_en"},     136'(rd_en),     136'(0));
    check_output({ctx, "_rd_addr"},   136'(rd_addr),   136'(0));
    check_output({ctx, "_out_data"},  out_data,        136'(0));
    check_output({ctx, "_out_valid"}, 136'(out_valid), 136'(0));
    check_output({ctx, "_busy"},      136'(busy),      136'(0));
    check_output({ctx, "_done"},      136'(done),      136'(0));
  endtask

  task automatic fill_const(input logic [17:0] x);
    for (int v = 0; v < NUM_VEC; v++) begin
      mem[v] = '0;
      for (int i = 0; i < 16; i++) mem[v][i*18 +: 18] = x;
    end
  endtask

  task automatic fill_pattern4();
    logic [17:0] pat [0:3];
    pat[0] = 18'd128; pat[1] = 18'd64; pat[2] = 18'd0; pat[3] = 18'd256;
    for (int v = 0; v < NUM_VEC; v++) begin
      mem[v] = '0;
      for (int i = 0; i < 16; i++) mem[v][i*18 +: 18] = pat[i % 4];
    end
  endtask

  // Mostly values within 0..m, some full-range values to hit saturation,
  // and random padding bits that must be ignored.
  task automatic fill_random(input int unsigned m);
    int unsigned x;
    for (int v = 0; v < NUM_VEC; v++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0 || m == 0) x = $urandom_range(0, 262143);
        else x = $urandom_range(0, m);
        mem[v][i*18 +: 18] = 18'(x);
      end
      mem[v][295:288] = 8'($urandom);
    end
  endtask

  // mode 0: out_ready high; mode 1: random backpressure;
  // mode 2: 10-cycle stall on vector 3 with a stray start pulse.
  task automatic apply_stimulus(input int unsigned m, input int mode, input int exp_lat,
                                output int base);
    int   base_addr, base_done, cyc, stall;
    logic seen_done;
    logic [135:0] held;
    base      = got_q.size();
    base_addr = addr_q.size();
    base_done = done_total;
    cyc = 0; stall = 0; seen_done = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    vec_max = 18'(m);
    out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (!seen_done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      vec_max = 18'(m);
      if (done) seen_done = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) begin
        if (out_valid && (got_q.size() - base) == 3 && stall < 10) begin
          if (stall == 0) held = out_data;
          else check_output("stall_data_stable", out_data, held);
          check_output("stall_no_rd_en", 136'(rd_en), 136'(0));
          if (stall == 5) begin
            start = 1'b1;
            vec_max = 18'(m ^ 1);
          end
          out_ready = 1'b0;
          stall++;
        end else out_ready = 1'b1;
      end
    end
    check_output("done_seen", 136'(seen_done), 136'(1));
    check_output("busy_in_done_cycle", 136'(busy), 136'(1));
    if (exp_lat > 0) check_output("done_latency", 136'(cyc), 136'(exp_lat));
    if (mode == 2) check_output("stall_cycles", 136'(stall), 136'(10));
    @(negedge clk);
    check_output("busy_after_done", 136'(busy), 136'(0));
    check_output("done_single_pulse", 136'(done_total - base_done), 136'(1));
    check_output("handshake_count", 136'(got_q.size() - base), 136'(NUM_VEC));
    check_output("read_count", 136'(addr_q.size() - base_addr), 136'(NUM_VEC));
    for (int i = 0; i < NUM_VEC && (base + i) < got_q.size(); i++)
      check_output($sformatf("word_m%0d_v%0d", m, i), got_q[base + i], model_word(m, mem[i]));
    for (int i = 0; i < NUM_VEC && (base_addr + i) < addr_q.size(); i++)
      check_output($sformatf("rd_addr_v%0d", i), 136'(addr_q[base_addr + i]), 136'(i));
  endtask

  initial begin
    int base, base_done, cyc;
    int unsigned m;
    logic hit;
    logic [135:0] exp_w;

    rst_n = 1'b0; start = 1'b0; vec_max = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full-scale batch: every lane at max, exact reciprocal 65536
    fill_const(18'd255);
    apply_stimulus(255, 0, 89, base);
    check_output("max255_word0", got_q[base], {8'd8, {16{8'hFF}}});

    // vec_max 256 with mid, quarter, zero and saturating lanes
    fill_pattern4();
    apply_stimulus(256, 0, 89, base);
    check_output("max256_lanes", got_q[base][31:0], 32'hFF_00_40_80);
    check_output("max256_scale", 136'(got_q[base][135:128]), 136'(9));

    // Exact half: 5 * 255/510 = 2.5
    fill_const(18'd5);
`ifdef PPU_QUANT_RNE_EN
    exp_w = 136'(2);
`else
    exp_w = 136'(3);
`endif
    apply_stimulus(510, 0, 89, base);
    check_output("half_lane0", 136'(got_q[base][7:0]), exp_w);

    // Zero max skips the divider entirely
    fill_random(0);
    apply_stimulus(0, 0, 65, base);
    check_output("zero_max_word0", got_q[base], 136'(0));

    // Randomized batches with random backpressure
    for (int b = 0; b < 5; b++) begin
      case (b)
        0: m = 1;
        1: m = $urandom_range(2, 255);
        2: m = $urandom_range(256, 65535);
        3: m = $urandom_range(131072, 262143);
        default: m = $urandom_range(1, 262143);
      endcase
      fill_random(m);
      apply_stimulus(m, 1, 0, base);
    end

    // Stall on vector 3 with a start pulse that must be ignored
    m = $urandom_range(300, 4000);
    fill_random(m);
    apply_stimulus(m, 2, 0, base);

    // Reset during the division
    base_done = done_total;
    @(negedge clk);
    start = 1'b1; vec_max = 18'd1000; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_output("mid_div_busy", 136'(busy), 136'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_div_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("mid_div_no_done", 136'(done_total - base_done), 136'(0));

    // Reset while holding an output word
    fill_random(300);
    base = got_q.size();
    base_done = done_total;
    @(negedge clk);
    start = 1'b1; vec_max = 18'd300; out_ready = 1'b1;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 500) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if ((got_q.size() - base) >= 2) out_ready = 1'b0;
      if (out_valid && !out_ready) hit = 1'b1;
    end
    check_output("mid_out_reached", 136'(hit), 136'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_out_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("mid_out_no_done", 136'(done_total - base_done), 136'(0));

    // Clean batch afterwards, starting again from address 0
    m = 777;
    fill_random(m);
    apply_stimulus(m, 0, 89, base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
